// File: rtl/avalon_mem_burst_split_pkg.sv
// Shared widths, FSM states and the sub-burst sizing rule for avalon_mem_burst_split.
package avalon_mem_burst_pkg;

  localparam int ADDR_WIDTH        = 27;
  localparam int DATA_WIDTH        = 512;
  localparam int BE_WIDTH          = DATA_WIDTH / 8;
  localparam int S_BURST_CNT_WIDTH = 11;
  localparam int M_BURST_CNT_WIDTH = 7;
  localparam int OFF_BITS          = M_BURST_CNT_WIDTH - 1;
  localparam int M_MAX_BURST       = 1 << OFF_BITS;

  typedef enum logic [1:0] {IDLE, RD_SPLIT, WR_DATA} state_t;

  // Beats left before the next M_MAX_BURST-aligned boundary, capped by what remains.
  function automatic logic [M_BURST_CNT_WIDTH-1:0] chunk_len(
    input logic [OFF_BITS-1:0]          addr,
    input logic [S_BURST_CNT_WIDTH-1:0] remaining
  );
    logic [M_BURST_CNT_WIDTH-1:0] room;
    room = M_BURST_CNT_WIDTH'(M_MAX_BURST) - {1'b0, addr};
    if (remaining < S_BURST_CNT_WIDTH'(room)) return remaining[M_BURST_CNT_WIDTH-1:0];
    return room;
  endfunction

endpackage

// File: rtl/avalon_mem_burst_split_if.sv
// Avalon-MM command/data bundle; BC_WIDTH differs between the upstream and downstream side.
interface avalon_mem_burst_split_if #(
  parameter int BC_WIDTH = avalon_mem_burst_pkg::S_BURST_CNT_WIDTH
);
  import avalon_mem_burst_pkg::*;

  logic                  waitrequest;
  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] address;
  logic [BC_WIDTH-1:0]   burstcount;
  logic [DATA_WIDTH-1:0] writedata;
  logic [BE_WIDTH-1:0]   byteenable;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;

  modport master (
    input  waitrequest, readdata, readdatavalid,
    output read, write, address, burstcount, writedata, byteenable
  );

  modport slave (
    output waitrequest, readdata, readdatavalid,
    input  read, write, address, burstcount, writedata, byteenable
  );

endinterface

// File: rtl/avalon_mem_burst_split.sv
// Splits upstream Avalon-MM bursts into boundary-aligned sub-bursts of at most M_MAX_BURST beats.
module avalon_mem_burst_split
  import avalon_mem_burst_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  avalon_mem_burst_split_if.slave   s,
  avalon_mem_burst_split_if.master  m
);

  state_t                       state;
  logic                         out_valid;
  logic                         out_read;
  logic                         out_write;
  logic [ADDR_WIDTH-1:0]        out_address;
  logic [M_BURST_CNT_WIDTH-1:0] out_burstcount;
  logic [DATA_WIDTH-1:0]        out_writedata;
  logic [BE_WIDTH-1:0]          out_byteenable;
  logic [ADDR_WIDTH-1:0]        next_addr;
  logic [S_BURST_CNT_WIDTH-1:0] rem_cnt;
  logic [M_BURST_CNT_WIDTH-1:0] sub_cnt;
  logic [DATA_WIDTH-1:0]        rd_data;
  logic                         rd_valid;

  logic                         busy;
  logic                         load_ok;
  logic                         accept_rd;
  logic                         accept_wr;
  logic [S_BURST_CNT_WIDTH-1:0] req_len;
  logic [M_BURST_CNT_WIDTH-1:0] first_len;
  logic [M_BURST_CNT_WIDTH-1:0] split_len;

  assign busy          = (state == RD_SPLIT);
  assign load_ok       = !out_valid || !m.waitrequest;
  assign s.waitrequest = busy || (out_valid && m.waitrequest);
  assign accept_rd     = s.read && !s.waitrequest && (state == IDLE);
  assign accept_wr     = s.write && !s.waitrequest && !accept_rd;
  assign req_len       = (s.burstcount == '0) ? S_BURST_CNT_WIDTH'(1) : s.burstcount;
  assign first_len     = chunk_len(s.address[OFF_BITS-1:0], req_len);
  assign split_len     = chunk_len(next_addr[OFF_BITS-1:0], rem_cnt);

  assign m.read       = out_read;
  assign m.write      = out_write;
  assign m.address    = out_address;
  assign m.burstcount = out_burstcount;
  assign m.writedata  = out_writedata;
  assign m.byteenable = out_byteenable;
  assign s.readdata      = rd_data;
  assign s.readdatavalid = rd_valid;

  // The output register empties when the downstream takes it; a new load in the same
  // cycle overrides the clear. Address/burstcount only change at a sub-burst start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      out_valid      <= 1'b0;
      out_read       <= 1'b0;
      out_write      <= 1'b0;
      out_address    <= '0;
      out_burstcount <= '0;
      out_writedata  <= '0;
      out_byteenable <= '0;
      next_addr      <= '0;
      rem_cnt        <= '0;
      sub_cnt        <= '0;
    end else begin
      if (load_ok) begin
        out_valid <= 1'b0;
        out_read  <= 1'b0;
        out_write <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept_rd) begin
            out_valid      <= 1'b1;
            out_read       <= 1'b1;
            out_address    <= s.address;
            out_burstcount <= first_len;
            next_addr      <= s.address + ADDR_WIDTH'(first_len);
            rem_cnt        <= req_len - S_BURST_CNT_WIDTH'(first_len);
            if (req_len != S_BURST_CNT_WIDTH'(first_len)) state <= RD_SPLIT;
          end else if (accept_wr) begin
            out_valid      <= 1'b1;
            out_write      <= 1'b1;
            out_address    <= s.address;
            out_burstcount <= first_len;
            out_writedata  <= s.writedata;
            out_byteenable <= s.byteenable;
            next_addr      <= s.address + ADDR_WIDTH'(first_len);
            rem_cnt        <= req_len - S_BURST_CNT_WIDTH'(1);
            sub_cnt        <= first_len - M_BURST_CNT_WIDTH'(1);
            if (req_len > S_BURST_CNT_WIDTH'(1)) state <= WR_DATA;
          end
        end
        RD_SPLIT: begin
          if (load_ok) begin
            out_valid      <= 1'b1;
            out_read       <= 1'b1;
            out_address    <= next_addr;
            out_burstcount <= split_len;
            next_addr      <= next_addr + ADDR_WIDTH'(split_len);
            rem_cnt        <= rem_cnt - S_BURST_CNT_WIDTH'(split_len);
            if (rem_cnt == S_BURST_CNT_WIDTH'(split_len)) state <= IDLE;
          end
        end
        WR_DATA: begin
          if (accept_wr) begin
            out_valid      <= 1'b1;
            out_write      <= 1'b1;
            out_writedata  <= s.writedata;
            out_byteenable <= s.byteenable;
            rem_cnt        <= rem_cnt - S_BURST_CNT_WIDTH'(1);
            if (sub_cnt == '0) begin
              out_address    <= next_addr;
              out_burstcount <= split_len;
              next_addr      <= next_addr + ADDR_WIDTH'(split_len);
              sub_cnt        <= split_len - M_BURST_CNT_WIDTH'(1);
            end else begin
              sub_cnt <= sub_cnt - M_BURST_CNT_WIDTH'(1);
            end
            if (rem_cnt == S_BURST_CNT_WIDTH'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_data  <= m.readdata;
      rd_valid <= m.readdatavalid;
    end
  end

  a_no_read_write_together: assert property (@(posedge clk) disable iff (!reset_n)
    !(s.read && s.write && !s.waitrequest));

  a_nonzero_burstcount: assert property (@(posedge clk) disable iff (!reset_n)
    ((s.read || s.write) && !s.waitrequest && state == IDLE) |-> (s.burstcount != '0));

endmodule

// File: tb/tb_avalon_mem_burst_split.sv
// Directed bench: a request-level model predicts sub-bursts, write beats and read data.
module tb_avalon_mem_burst_split;
  import avalon_mem_burst_pkg::*;

  typedef struct {
    bit          wr;
    int unsigned addr;
    int unsigned len;
  } cmd_t;

  typedef struct {
    logic [DATA_WIDTH-1:0] d;
    logic [BE_WIDTH-1:0]   be;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  cmd_t        exp_cmd_q[$];
  beat_t       exp_wr_q[$];
  logic [DATA_WIDTH-1:0] exp_rd_q[$];
  int unsigned rsp_q[$];
  int          stamps[$];
  int unsigned wr_left = 0;
  int unsigned cur_addr = 0;
  int unsigned cur_len = 0;
  logic        prev_v = 1'b0;
  logic [DATA_WIDTH-1:0] prev_d = '0;

  avalon_mem_burst_split_if #(.BC_WIDTH(S_BURST_CNT_WIDTH)) s_if();
  avalon_mem_burst_split_if #(.BC_WIDTH(M_BURST_CNT_WIDTH)) m_if();

  avalon_mem_burst_split dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s       (s_if.slave),
    .m       (m_if.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void checkOutput(input string name, input logic [DATA_WIDTH-1:0] act,
                                      input logic [DATA_WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mem_data(input int unsigned a);
    logic [31:0] w;
    w = (a & 32'h07FF_FFFF) ^ 32'hC0DE_0000;
    return {16{w}};
  endfunction

  // Request-level model: split on 64-beat aligned boundaries, address wraps at 2^27.
  function automatic void model_plan(input bit wr, input int unsigned addr, input int unsigned n);
    int unsigned a = addr;
    int unsigned left = n;
    int unsigned room;
    int unsigned len;
    beat_t b;
    while (left > 0) begin
      room = 64 - (a % 64);
      len  = (left < room) ? left : room;
      exp_cmd_q.push_back('{wr, a, len});
      a    = (a + len) & 32'h07FF_FFFF;
      left = left - len;
    end
    for (int i = 0; i < int'(n); i++) begin
      if (wr) begin
        b.d  = DATA_WIDTH'(i);
        b.be = (i % 2 == 0) ? {8{8'h55}} : {8{8'hAA}};
        exp_wr_q.push_back(b);
      end else begin
        exp_rd_q.push_back(mem_data(addr + i));
      end
    end
  endfunction

  // Downstream memory: capture accepted reads, return one beat per cycle.
  always @(negedge clk) begin
    if (reset_n && m_if.read && !m_if.waitrequest)
      for (int i = 0; i < int'(m_if.burstcount); i++) rsp_q.push_back(m_if.address + i);
  end

  always @(posedge clk) begin
    prev_v = m_if.readdatavalid;
    prev_d = m_if.readdata;
    if (!reset_n) begin
      prev_v = 1'b0;
      rsp_q.delete();
    end
    #1;
    if (reset_n && rsp_q.size() > 0) begin
      m_if.readdatavalid = 1'b1;
      m_if.readdata      = mem_data(rsp_q.pop_front());
    end else begin
      m_if.readdatavalid = 1'b0;
    end
  end

  // Compare process: every downstream transfer and every upstream read beat.
  always @(negedge clk) begin
    cmd_t  c;
    beat_t b;
    if (reset_n) begin
      if (m_if.read && !m_if.waitrequest) begin
        stamps.push_back(cyc);
        if (exp_cmd_q.size() == 0) checkOutput("extra_rd_cmd", 1, 0);
        else begin
          c = exp_cmd_q.pop_front();
          checkOutput("rd_cmd_kind", 0, DATA_WIDTH'(c.wr));
          checkOutput("rd_cmd_addr", m_if.address, c.addr);
          checkOutput("rd_cmd_len", m_if.burstcount, c.len);
        end
      end
      if (m_if.write && !m_if.waitrequest) begin
        if (wr_left == 0) begin
          if (exp_cmd_q.size() == 0) checkOutput("extra_wr_cmd", 1, 0);
          else begin
            c = exp_cmd_q.pop_front();
            checkOutput("wr_cmd_kind", 1, DATA_WIDTH'(c.wr));
            cur_addr = c.addr;
            cur_len  = c.len;
            wr_left  = c.len;
          end
        end
        checkOutput("wr_addr", m_if.address, cur_addr);
        checkOutput("wr_len", m_if.burstcount, cur_len);
        if (wr_left > 0) wr_left--;
        if (exp_wr_q.size() == 0) checkOutput("extra_wr_beat", 1, 0);
        else begin
          b = exp_wr_q.pop_front();
          checkOutput("wr_data", m_if.writedata, b.d);
          checkOutput("wr_be", m_if.byteenable, b.be);
        end
      end
      checkOutput("rd_latency_valid", s_if.readdatavalid, prev_v);
      if (s_if.readdatavalid) begin
        checkOutput("rd_latency_data", s_if.readdata, prev_d);
        if (exp_rd_q.size() == 0) checkOutput("extra_rd_beat", 1, 0);
        else checkOutput("rd_data", s_if.readdata, exp_rd_q.pop_front());
      end
    end
  end

  // Drives one upstream burst; call and return at posedge+1.
  task automatic applyStimulus(input bit wr, input int unsigned addr, input int unsigned n);
    int beats;
    beats = wr ? int'(n) : 1;
    for (int i = 0; i < beats; i++) begin
      s_if.read       = !wr;
      s_if.write      = wr;
      s_if.address    = ADDR_WIDTH'(addr);
      s_if.burstcount = S_BURST_CNT_WIDTH'(n);
      s_if.writedata  = DATA_WIDTH'(i);
      s_if.byteenable = (i % 2 == 0) ? {8{8'h55}} : {8{8'hAA}};
      begin : wait_accept
        for (int t = 0; t < 200; t++) begin
          @(negedge clk);
          if (!s_if.waitrequest) disable wait_accept;
        end
        checkOutput("accept_timeout", 1, 0);
      end
      @(posedge clk);
      #1;
    end
    s_if.read  = 1'b0;
    s_if.write = 1'b0;
  endtask

  task automatic wait_drain();
    begin : drain
      for (int t = 0; t < 3000; t++) begin
        @(negedge clk);
        if (exp_cmd_q.size() == 0 && exp_wr_q.size() == 0 && exp_rd_q.size() == 0 &&
            rsp_q.size() == 0) disable drain;
      end
      checkOutput("drain_timeout", 1, 0);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic stall_at_beat63();
    begin : find
      for (int t = 0; t < 500; t++) begin
        @(posedge clk);
        #2;
        if (m_if.write && m_if.writedata == DATA_WIDTH'(63)) disable find;
      end
      checkOutput("stall_trigger", 0, 1);
    end
    m_if.waitrequest = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("s_wait_mirror_hi", s_if.waitrequest, 1);
      checkOutput("beat63_held", m_if.writedata, 63);
      @(posedge clk);
      #2;
    end
    m_if.waitrequest = 1'b0;
    @(negedge clk);
    checkOutput("s_wait_mirror_lo", s_if.waitrequest, 0);
  endtask

  initial begin
    s_if.read = 1'b0; s_if.write = 1'b0; s_if.address = '0; s_if.burstcount = '0;
    s_if.writedata = '0; s_if.byteenable = '0;
    m_if.waitrequest = 1'b0; m_if.readdatavalid = 1'b0; m_if.readdata = '0;

    #1;
    checkOutput("rst_m_read", m_if.read, 0);
    checkOutput("rst_m_write", m_if.write, 0);
    checkOutput("rst_m_address", m_if.address, 0);
    checkOutput("rst_m_burstcount", m_if.burstcount, 0);
    checkOutput("rst_s_rdv", s_if.readdatavalid, 0);
    checkOutput("rst_s_readdata", s_if.readdata, 0);
    #20 reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_s_wait", s_if.waitrequest, 0);

    // Single-beat read.
    model_plan(0, 32'h10, 1);
    checkOutput("pin1_addr", exp_cmd_q[0].addr, 32'h10);
    checkOutput("pin1_len", exp_cmd_q[0].len, 1);
    applyStimulus(0, 32'h10, 1);
    wait_drain();

    // Read crossing two boundaries, commands back to back.
    model_plan(0, 32'h3C, 100);
    checkOutput("pin2_n", exp_cmd_q.size(), 3);
    checkOutput("pin2_a0", exp_cmd_q[0].addr, 32'h3C);
    checkOutput("pin2_l0", exp_cmd_q[0].len, 4);
    checkOutput("pin2_a1", exp_cmd_q[1].addr, 32'h40);
    checkOutput("pin2_l1", exp_cmd_q[1].len, 64);
    checkOutput("pin2_a2", exp_cmd_q[2].addr, 32'h80);
    checkOutput("pin2_l2", exp_cmd_q[2].len, 32);
    stamps.delete();
    applyStimulus(0, 32'h3C, 100);
    wait_drain();
    checkOutput("rd_cmd_count", stamps.size(), 3);
    if (stamps.size() == 3) begin
      checkOutput("rd_back_to_back_1", stamps[1] - stamps[0], 1);
      checkOutput("rd_back_to_back_2", stamps[2] - stamps[1], 1);
    end

    // 130-beat write.
    model_plan(1, 0, 130);
    checkOutput("pin3_l0", exp_cmd_q[0].len, 64);
    checkOutput("pin3_a1", exp_cmd_q[1].addr, 32'h40);
    checkOutput("pin3_l2", exp_cmd_q[2].len, 2);
    applyStimulus(1, 0, 130);
    wait_drain();

    // Same write with a 5-cycle downstream stall on beat 63.
    model_plan(1, 0, 130);
    fork
      applyStimulus(1, 0, 130);
      stall_at_beat63();
    join
    wait_drain();

    // Reset in the middle of a split read.
    model_plan(0, 0, 256);
    applyStimulus(0, 0, 256);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_m_read", m_if.read, 0);
    checkOutput("midrst_m_address", m_if.address, 0);
    checkOutput("midrst_m_burstcount", m_if.burstcount, 0);
    checkOutput("midrst_s_rdv", s_if.readdatavalid, 0);
    checkOutput("midrst_s_wait", s_if.waitrequest, 0);
    exp_cmd_q.delete();
    exp_rd_q.delete();
    exp_wr_q.delete();
    wr_left = 0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postrst_s_wait", s_if.waitrequest, 0);
    model_plan(0, 32'h100, 2);
    applyStimulus(0, 32'h100, 2);
    wait_drain();

    // Address wrap at the top of the space.
    model_plan(0, 32'h07FF_FFFC, 8);
    checkOutput("pin6_a0", exp_cmd_q[0].addr, 32'h07FF_FFFC);
    checkOutput("pin6_l0", exp_cmd_q[0].len, 4);
    checkOutput("pin6_a1", exp_cmd_q[1].addr, 0);
    checkOutput("pin6_l1", exp_cmd_q[1].len, 4);
    applyStimulus(0, 32'h07FF_FFFC, 8);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
